shift_rotate_seq: RTL and testbench

- Iterative, parametrised shift/rotate unit for the CPU datapath; successor to the fixed 8-bit combinational right-rotator.
- Supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand.
- Applies one power-of-two stage per clock, so area stays at a single stage mux.
- Sits beside the ALU; the control unit starts an operation and waits on DONE.

---
 rtl/shift_rotate_seq.sv | 114 +++++++++++
 tb/tb_shift_rotate_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_seq.sv
// Iterative shift/rotate unit: one power-of-two stage per clock (SLL/SRL/SRA/ROR).
// Optional macro SHIFT_ROTATE_EARLY_DONE_EN ends SHIFT once no higher amount bits remain.
module shift_rotate_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int STAGES = $clog2(WIDTH);
  localparam int K_W    = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [1:0]         mode_q, mode_d;
  logic [STAGES-1:0]  amt_q, amt_d;
  logic [K_W-1:0]     k_q, k_d;

  logic [31:0]        amt_ext;
  logic               ovf;
  logic [31:0]        sh;
  logic [WIDTH-1:0]   shifted;
  logic               last_stage;

  assign amt_ext = 32'(amt_i);
  // Rotates wrap, so only linear shifts can overflow past the operand width
  assign ovf     = (mode_i != M_ROR) && (amt_ext >= 32'(WIDTH));
  assign sh      = 32'd1 << k_q;

  always_comb begin
    shifted = work_q;
    case (mode_q)
      M_SLL:   shifted = work_q << sh;
      M_SRL:   shifted = work_q >> sh;
      M_SRA:   shifted = $signed(work_q) >>> sh;
      default: shifted = (work_q >> sh) | (work_q << (32'(WIDTH) - sh));
    endcase
  end

`ifdef SHIFT_ROTATE_EARLY_DONE_EN
  assign last_stage = (k_q == K_W'(STAGES - 1)) ||
                      ((32'(amt_q) >> (32'(k_q) + 32'd1)) == 32'd0);
`else
  assign last_stage = (k_q == K_W'(STAGES - 1));
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    amt_d   = amt_q;
    k_d     = k_q;
    case (state_q)
      S_SHIFT: begin
        if (amt_q[k_q]) work_d = shifted;
        k_d = k_q + K_W'(1);
        if (last_stage) begin
          state_d = S_DONE;
          k_d     = '0;
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start_i) begin
          state_d = S_SHIFT;
          mode_d  = mode_i;
          k_d     = '0;
          if (ovf) begin
            amt_d  = '0;
            work_d = (mode_i == M_SRA) ? {WIDTH{data_in_i[WIDTH-1]}} : '0;
          end else begin
            amt_d  = amt_ext[STAGES-1:0];
            work_d = data_in_i;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      mode_q  <= '0;
      amt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
    end
  end

  assign data_out_o = work_q;
  assign busy_o     = (state_q == S_SHIFT);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Self-checking bench for shift_rotate_seq against a behavioural shift/rotate model.
module tb_shift_rotate_seq;
  localparam int W = 8;
  localparam int A = 8;
  localparam int S = $clog2(W);

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   mode;
  logic [W-1:0] din;
  logic [A-1:0] amt;
  logic [W-1:0] dout;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  shift_rotate_seq #(.WIDTH(W), .AMT_W(A)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .data_in_i(din), .amt_i(amt), .data_out_o(dout), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] d, input int a);
    logic [W-1:0] r;
    r = d;
    if (m == 2'b11) begin
      for (int i = 0; i < a % W; i++) r = {r[0], r[W-1:1]};
    end else if (a >= W) begin
      r = (m == 2'b10) ? {W{d[W-1]}} : '0;
    end else begin
      for (int i = 0; i < a; i++)
        case (m)
          2'b00:   r = {r[W-2:0], 1'b0};
          2'b01:   r = {1'b0, r[W-1:1]};
          default: r = {r[W-1], r[W-1:1]};
        endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] m, input int a);
`ifdef SHIFT_ROTATE_EARLY_DONE_EN
    int eff, hi;
    eff = (m == 2'b11) ? a % W : ((a >= W) ? 0 : a);
    hi  = 1;
    for (int i = 0; i < S; i++) if ((eff >> i) & 1) hi = i + 1;
    return hi;
`else
    return S;
`endif
  endfunction

  // Issues one operation and reports edges-to-DONE, BUSY cycle count and result.
  task automatic do_op(input logic [1:0] m, input logic [W-1:0] d, input int a,
                       output int lat, output int bcnt, output logic [W-1:0] res,
                       output logic busy_at_done);
    int cyc;
    @(negedge clk);
    start = 1'b1; mode = m; din = d; amt = A'(a);
    @(posedge clk);
    #1 start = 1'b0; mode = ~m; din = ~d; amt = '1;
    cyc = 0; bcnt = 0; lat = -1; res = 'x; busy_at_done = 1'bx;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        lat = cyc - 1; res = dout; busy_at_done = busy;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; mode = 2'b11; din = 8'h96; amt = 8'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dout=%h, want 0 0 00", busy, done, dout);
    end
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [1:0]   tm [12] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11,
                              2'b11, 2'b11, 2'b11, 2'b00};
    logic [W-1:0] td [12] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h46, 8'h96,
                              8'h96, 8'h96, 8'h96, 8'h81};
    int           ta [12] = '{3, 2, 2, 1, 9, 200, 8, 11, 1, 0, 4, 7};
    logic [W-1:0] tr [12] = '{8'hD2, 8'hE5, 8'h25, 8'h2C, 8'h00, 8'hFF, 8'h00, 8'hD2,
                              8'h4B, 8'h96, 8'h69, 8'h80};
    int lat, bcnt; logic [W-1:0] res; logic bad;
    for (int i = 0; i < 12; i++) begin
      do_op(tm[i], td[i], ta[i], lat, bcnt, res, bad);
      checks++;
      if (res !== tr[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, res, tr[i]);
      end
      checks++;
      if (lat != model_lat(tm[i], ta[i]) || bcnt != lat || bad !== 1'b0) begin
        errors++;
        $display("FAIL directed_timing[%0d]: lat=%0d busy_cycles=%0d busy@done=%b want lat=%0d", i,
                 lat, bcnt, bad, model_lat(tm[i], ta[i]));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || dout !== res) begin
        errors++;
        $display("FAIL directed_hold[%0d]: done=%b dout=%h want 0 %h", i, done, dout, res);
      end
    end
  endtask

  task automatic test_random;
    int lat, bcnt, a; logic [W-1:0] res, d, exp; logic [1:0] m; logic bad;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom);
      d = W'($urandom);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      exp = model(m, d, a);
      do_op(m, d, a, lat, bcnt, res, bad);
      checks++;
      if (res !== exp || lat != model_lat(m, a) || bcnt != lat) begin
        errors++;
        $display("FAIL random[%0d] m=%0d d=%h a=%0d: got %h lat=%0d busy=%0d want %h lat=%0d",
                 i, m, d, a, res, lat, bcnt, exp, model_lat(m, a));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [1:0] om [64]; logic [W-1:0] od [64]; int oa [64];
    int acc, dedge, e, nacc, ndone;
    logic [W-1:0] exp;
    @(negedge clk);
    start = 1'b1;
    om[0] = 2'($urandom); od[0] = W'($urandom); oa[0] = $urandom_range(0, 12);
    mode = om[0]; din = od[0]; amt = A'(oa[0]);
    acc = 0; dedge = model_lat(om[0], oa[0]); exp = model(om[0], od[0], oa[0]);
    nacc = -1; ndone = 0;
    for (int c = 1; c < 64; c++) begin
      @(negedge clk);
      e = c - 1;
      checks++;
      if (done !== (e == dedge) || busy !== (e >= acc && e < dedge)) begin
        errors++;
        $display("FAIL b2b_ctrl edge %0d: done=%b busy=%b want %b %b", e, done, busy,
                 e == dedge, e >= acc && e < dedge);
      end
      if (e == dedge) begin
        ndone++;
        checks++;
        if (dout !== exp) begin
          errors++;
          $display("FAIL b2b_result edge %0d: got %h want %h", e, dout, exp);
        end
        nacc = c;
      end
      om[c] = 2'($urandom); od[c] = W'($urandom); oa[c] = $urandom_range(0, 12);
      mode = om[c]; din = od[c]; amt = A'(oa[c]);
      if (c == nacc) begin
        acc = c; dedge = c + model_lat(om[c], oa[c]); exp = model(om[c], od[c], oa[c]);
      end
    end
    checks++;
    if (ndone < 10) begin
      errors++;
      $display("FAIL b2b_count: %0d completions, want >= 10", ndone);
    end
    start = 1'b0;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    start = 1'b1; mode = 2'b11; din = 8'h96; amt = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b dout=%h want 0 0 00", busy, done, dout);
    end
    reset = 1'b0;
    seen = 0;
    repeat (2 * S + 4) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort: %0d busy/done cycles after abort, want 0", seen);
    end
  endtask

`ifdef SHIFT_ROTATE_EARLY_DONE_EN
  task automatic test_early_done;
    int lat, bcnt; logic [W-1:0] res; logic bad;
    do_op(2'b10, 8'h96, 200, lat, bcnt, res, bad);
    checks++;
    if (lat != 1 || res !== 8'hFF) begin
      errors++;
      $display("FAIL early_overflow: lat=%0d res=%h want 1 FF", lat, res);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0; mode = '0; din = '0; amt = '0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
`ifdef SHIFT_ROTATE_EARLY_DONE_EN
    test_early_done;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
